// File: rtl/fuzz_sig_pkg.sv
// Shared types and helpers for the fuzz signature harness.
// Holds the signature width, the LFSR/MISR step and the run FSM states.
package fuzz_sig_pkg;

    localparam int          SIG_W     = 32;
    localparam logic [31:0] LFSR_MASK = 32'hEDB88320;

    typedef enum logic [2:0] {
        IDLE,
        ZERO,
        RUN,
        DRAIN,
        CHECK
    } state_t;

    // Right-shift Galois step, shared by the stimulus LFSR and the MISR.
    function automatic logic [SIG_W-1:0] lfsr_step(input logic [SIG_W-1:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

endpackage

// File: rtl/fuzz_sig_harness_if.sv
// Stimulus/response bundle between the harness and the DUT under test.
// master: drives stim/stim_valid, samples dut_y. slave: the DUT side.
interface fuzz_sig_harness_if #(
    parameter int IN_W  = 33,
    parameter int OUT_W = 695
);

    logic [IN_W-1:0]  stim;
    logic             stim_valid;
    logic [OUT_W-1:0] dut_y;

    modport master (
        output stim,
        output stim_valid,
        input  dut_y
    );

    modport slave (
        input  stim,
        input  stim_valid,
        output dut_y
    );

endinterface

// File: rtl/fuzz_sig_misr.sv
// Folds a wide DUT output into 32 bits and compresses it into a MISR.
// Ports: clk, rst_n, clr_i (zero MISR), en_i (absorb y_i), y_i, misr_o.
module fuzz_sig_misr
    import fuzz_sig_pkg::*;
#(
    parameter int OUT_W = 695
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [OUT_W-1:0] y_i,
    output logic [SIG_W-1:0] misr_o
);

    localparam int NCH = (OUT_W + SIG_W - 1) / SIG_W;

    logic [NCH*SIG_W-1:0] pad;
    logic [SIG_W-1:0]     fold;
    logic [SIG_W-1:0]     misr_q;

    // Top chunk is zero-padded before the XOR fold.
    always_comb begin
        pad = '0;
        pad[OUT_W-1:0] = y_i;
        fold = '0;
        for (int i = 0; i < NCH; i++) begin
            fold = fold ^ pad[i*SIG_W +: SIG_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misr_q <= '0;
        end else if (clr_i) begin
            misr_q <= '0;
        end else if (en_i) begin
            misr_q <= lfsr_step(misr_q) ^ fold;
        end
    end

    assign misr_o = misr_q;

endmodule

// File: rtl/fuzz_sig_harness.sv
// Drives NUM_VEC LFSR vectors into a DUT, captures its output LATENCY
// cycles later into a MISR and compares the result against exp_sig.
// Ports: clk, rst_n, start, exp_sig; dut_if (stim, stim_valid, dut_y);
// busy, done (one-cycle), pass and sig (held until the next run).
// Optional FUZZ_SIG_MISMATCH_CAPTURE_EN adds ref_y, mismatch, first_bad_idx.
module fuzz_sig_harness
    import fuzz_sig_pkg::*;
#(
    parameter int          IN_W    = 33,
    parameter int          OUT_W   = 695,
    parameter int          NUM_VEC = 21,
    parameter int          LATENCY = 1,
    parameter logic [31:0] SEED    = 32'h1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [SIG_W-1:0]    exp_sig,
    fuzz_sig_harness_if.master  dut_if,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [SIG_W-1:0]    sig
`ifdef FUZZ_SIG_MISMATCH_CAPTURE_EN
    ,
    input  logic [OUT_W-1:0]    ref_y,
    output logic                mismatch,
    output logic [15:0]         first_bad_idx
`endif
);

    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [15:0] NV       = 16'(NUM_VEC);

    state_t           state_q;
    logic [31:0]      lfsr_q;
    logic [15:0]      vec_cnt_q;
    logic [15:0]      cap_cnt_q;
    logic [IN_W-1:0]  stim_q;
    logic             stim_valid_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] misr;
    logic             accept;
    logic             cap_en;
    logic             clean;

    // The same LFSR word repeated, truncated to the stimulus width.
    function automatic logic [IN_W-1:0] widen(input logic [31:0] s);
        logic [63:0] r;
        r = {s, s};
        return r[IN_W-1:0];
    endfunction

    assign accept = (state_q == IDLE) && start;

    generate
        if (LATENCY == 0) begin : g_lat0
            assign cap_en = stim_valid_q;
        end else begin : g_latn
            logic [LATENCY-1:0] vsr_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vsr_q <= '0;
                end else begin
                    vsr_q[0] <= stim_valid_q;
                    for (int i = 1; i < LATENCY; i++) begin
                        vsr_q[i] <= vsr_q[i-1];
                    end
                end
            end
            assign cap_en = vsr_q[LATENCY-1];
        end
    endgenerate

    fuzz_sig_misr #(
        .OUT_W (OUT_W)
    ) u_misr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (accept),
        .en_i   (cap_en),
        .y_i    (dut_if.dut_y),
        .misr_o (misr)
    );

`ifdef FUZZ_SIG_MISMATCH_CAPTURE_EN
    logic        mm_q;
    logic [15:0] bad_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm_q      <= 1'b0;
            bad_idx_q <= '0;
        end else if (accept) begin
            mm_q      <= 1'b0;
            bad_idx_q <= '0;
        end else if (cap_en && (dut_if.dut_y != ref_y)) begin
            mm_q <= 1'b1;
            if (!mm_q) begin
                bad_idx_q <= cap_cnt_q;
            end
        end
    end

    assign clean         = !mm_q;
    assign mismatch      = mm_q;
    assign first_bad_idx = bad_idx_q;
`else
    assign clean = 1'b1;
`endif

    // lfsr_q always holds the next vector to present; outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lfsr_q       <= SEED_EFF;
            vec_cnt_q    <= '0;
            cap_cnt_q    <= '0;
            stim_q       <= '0;
            stim_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            sig_q        <= '0;
        end else begin
            done_q <= 1'b0;
            if (cap_en) begin
                cap_cnt_q <= cap_cnt_q + 16'd1;
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= ZERO;
                        lfsr_q    <= SEED_EFF;
                        vec_cnt_q <= '0;
                        cap_cnt_q <= '0;
                        pass_q    <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                ZERO: begin
                    state_q      <= RUN;
                    stim_q       <= widen(lfsr_q);
                    stim_valid_q <= 1'b1;
                    lfsr_q       <= lfsr_step(lfsr_q);
                    vec_cnt_q    <= 16'd1;
                end
                RUN: begin
                    if (vec_cnt_q == NV) begin
                        stim_q       <= '0;
                        stim_valid_q <= 1'b0;
                        if (LATENCY == 0) begin
                            state_q <= CHECK;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end else begin
                        stim_q    <= widen(lfsr_q);
                        lfsr_q    <= lfsr_step(lfsr_q);
                        vec_cnt_q <= vec_cnt_q + 16'd1;
                    end
                end
                DRAIN: begin
                    if (cap_cnt_q == NV) begin
                        state_q <= CHECK;
                        done_q  <= 1'b1;
                    end
                end
                CHECK: begin
                    sig_q   <= misr;
                    pass_q  <= (misr == exp_sig) && clean;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dut_if.stim       = stim_q;
    assign dut_if.stim_valid = stim_valid_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign pass              = pass_q;
    assign sig               = sig_q;

endmodule

// File: tb/tb_fuzz_sig_harness.sv
// Scoreboard bench for fuzz_sig_harness: several small configurations,
// expected vectors/results queued by the stimulus, popped by monitors.
module tb_fuzz_sig_harness;

    typedef struct packed {
        logic [31:0] sig;
        logic        pass;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n  = 1'b0;
    logic rst3_n = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] sq0[$];
    logic [63:0] sq3[$];
    res_t        rq0[$];
    res_t        rq1[$];
    res_t        rq2[$];
    res_t        rq4[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] lstep(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'hEDB88320) : (s >> 1);
    endfunction

    // u0: stimulus order, zero DUT output
    logic        start0 = 0, busy0, done0, pass0;
    logic [31:0] exp0 = 0, sig0;
    fuzz_sig_harness_if #(.IN_W(32), .OUT_W(32)) bi0 ();
    assign bi0.dut_y = '0;
    // u1: constant-ones DUT, 32-bit output
    logic        start1 = 0, busy1, done1, pass1;
    logic [31:0] exp1 = 0, sig1;
    fuzz_sig_harness_if #(.IN_W(32), .OUT_W(32)) bi1 ();
    assign bi1.dut_y = '1;
    // u2: constant-ones DUT, 64-bit output (chunks cancel)
    logic        start2 = 0, busy2, done2, pass2;
    logic [31:0] exp2 = 0, sig2;
    fuzz_sig_harness_if #(.IN_W(32), .OUT_W(64)) bi2 ();
    assign bi2.dut_y = '1;
    // u3: default-size run, registered echo DUT, private reset
    logic        start3 = 0, busy3, done3, pass3;
    logic [31:0] exp3 = 0, sig3, y3q = 0;
    fuzz_sig_harness_if #(.IN_W(33), .OUT_W(32)) bi3 ();
    always @(posedge clk) y3q <= bi3.stim[31:0];
    assign bi3.dut_y = y3q;

`ifdef FUZZ_SIG_MISMATCH_CAPTURE_EN
    logic        mm0, mm1, mm2, mm3;
    logic [15:0] fb0, fb1, fb2, fb3;
    logic        start4 = 0, busy4, done4, pass4, mm4, rv4 = 0;
    logic [31:0] exp4 = 0, sig4, ref4 = 0;
    logic [15:0] fb4;
    int          vn4 = 0, rn4 = 0;
    fuzz_sig_harness_if #(.IN_W(32), .OUT_W(32)) bi4 ();
    always @(posedge clk) begin
        ref4 <= bi4.stim;
        rv4  <= bi4.stim_valid;
        rn4  <= vn4;
        if (bi4.stim_valid) vn4 <= vn4 + 1;
        else if (!busy4) vn4 <= 0;
    end
    assign bi4.dut_y = ref4 ^ {31'b0, (rv4 && rn4 == 4)};
    fuzz_sig_harness #(.IN_W(32), .OUT_W(32), .NUM_VEC(6),
                       .LATENCY(1), .SEED(32'h1)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .exp_sig(exp4),
        .dut_if(bi4), .busy(busy4), .done(done4), .pass(pass4),
        .sig(sig4), .ref_y(ref4), .mismatch(mm4), .first_bad_idx(fb4));
`endif

    fuzz_sig_harness #(.IN_W(32), .OUT_W(32), .NUM_VEC(3),
                       .LATENCY(1), .SEED(32'h1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .exp_sig(exp0),
        .dut_if(bi0), .busy(busy0), .done(done0), .pass(pass0),
        .sig(sig0)
`ifdef FUZZ_SIG_MISMATCH_CAPTURE_EN
        , .ref_y(bi0.dut_y), .mismatch(mm0), .first_bad_idx(fb0)
`endif
    );

    fuzz_sig_harness #(.IN_W(32), .OUT_W(32), .NUM_VEC(2),
                       .LATENCY(1), .SEED(32'h1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .exp_sig(exp1),
        .dut_if(bi1), .busy(busy1), .done(done1), .pass(pass1),
        .sig(sig1)
`ifdef FUZZ_SIG_MISMATCH_CAPTURE_EN
        , .ref_y(bi1.dut_y), .mismatch(mm1), .first_bad_idx(fb1)
`endif
    );

    fuzz_sig_harness #(.IN_W(32), .OUT_W(64), .NUM_VEC(2),
                       .LATENCY(1), .SEED(32'h1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .exp_sig(exp2),
        .dut_if(bi2), .busy(busy2), .done(done2), .pass(pass2),
        .sig(sig2)
`ifdef FUZZ_SIG_MISMATCH_CAPTURE_EN
        , .ref_y(bi2.dut_y), .mismatch(mm2), .first_bad_idx(fb2)
`endif
    );

    fuzz_sig_harness #(.IN_W(33), .OUT_W(32), .NUM_VEC(21),
                       .LATENCY(1), .SEED(32'h1)) u3 (
        .clk(clk), .rst_n(rst3_n), .start(start3), .exp_sig(exp3),
        .dut_if(bi3), .busy(busy3), .done(done3), .pass(pass3),
        .sig(sig3)
`ifdef FUZZ_SIG_MISMATCH_CAPTURE_EN
        , .ref_y(y3q), .mismatch(mm3), .first_bad_idx(fb3)
`endif
    );

    // ---------------- monitors ----------------
    int   nv0 = 0, nv3 = 0;
    int   nd0 = 0, nd1 = 0, nd2 = 0, nd3 = 0;
    logic pd0 = 0, pd1 = 0, pd2 = 0;
    res_t r0, r1, r2;

    always @(negedge clk) begin
        if (bi0.stim_valid) begin
            nv0++;
            if (sq0.size() == 0) chk("u0 extra vector", 64'd1, 64'd0);
            else chk("u0 stim", 64'(bi0.stim), sq0.pop_front());
        end
        if (bi3.stim_valid) begin
            nv3++;
            if (sq3.size() != 0) chk("u3 stim", 64'(bi3.stim), sq3.pop_front());
        end
        if (done3) nd3++;
    end

    always @(negedge clk) begin
        if (pd0) begin
            pd0 = 0;
            if (rq0.size() == 0) chk("u0 unexpected done", 64'd1, 64'd0);
            else begin
                r0 = rq0.pop_front();
                chk("u0 sig", 64'(sig0), 64'(r0.sig));
                chk("u0 pass", 64'(pass0), 64'(r0.pass));
                chk("u0 busy after done", 64'(busy0), 64'd0);
            end
        end
        if (done0) begin pd0 = 1; nd0++; end
    end

    always @(negedge clk) begin
        if (pd1) begin
            pd1 = 0;
            if (rq1.size() == 0) chk("u1 unexpected done", 64'd1, 64'd0);
            else begin
                r1 = rq1.pop_front();
                chk("u1 sig", 64'(sig1), 64'(r1.sig));
                chk("u1 pass", 64'(pass1), 64'(r1.pass));
                chk("u1 busy after done", 64'(busy1), 64'd0);
            end
        end
        if (done1) begin pd1 = 1; nd1++; end
    end

    always @(negedge clk) begin
        if (pd2) begin
            pd2 = 0;
            if (rq2.size() == 0) chk("u2 unexpected done", 64'd1, 64'd0);
            else begin
                r2 = rq2.pop_front();
                chk("u2 sig", 64'(sig2), 64'(r2.sig));
                chk("u2 pass", 64'(pass2), 64'(r2.pass));
            end
        end
        if (done2) begin pd2 = 1; nd2++; end
    end

`ifdef FUZZ_SIG_MISMATCH_CAPTURE_EN
    logic pd4 = 0;
    res_t r4;
    always @(negedge clk) begin
        if (pd4) begin
            pd4 = 0;
            if (rq4.size() == 0) chk("u4 unexpected done", 64'd1, 64'd0);
            else begin
                r4 = rq4.pop_front();
                chk("u4 sig", 64'(sig4), 64'(r4.sig));
                chk("u4 pass", 64'(pass4), 64'(r4.pass));
                chk("u4 mismatch", 64'(mm4), 64'd1);
                chk("u4 first_bad_idx", 64'(fb4), 64'd4);
            end
        end
        if (done4) pd4 = 1;
    end
`endif

    // ---------------- stimulus helpers ----------------
    function automatic logic get_done(input int w);
        case (w)
            0: return done0;
            1: return done1;
            2: return done2;
            3: return done3;
`ifdef FUZZ_SIG_MISMATCH_CAPTURE_EN
            4: return done4;
`endif
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w)
            0: start0 = v;
            1: start1 = v;
            2: start2 = v;
            3: start3 = v;
`ifdef FUZZ_SIG_MISMATCH_CAPTURE_EN
            4: start4 = v;
`endif
            default: ;
        endcase
    endtask

    // Returns at the negedge of the ZERO cycle.
    task automatic pulse(input int w);
        @(negedge clk);
        set_start(w, 1'b1);
        @(negedge clk);
        set_start(w, 1'b0);
    endtask

    task automatic wait_done(input int w, input string nm);
        int i;
        i = 0;
        while (!get_done(w) && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (!get_done(w)) chk({nm, " done timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    int d1, d3;
    logic [31:0] lm, mm;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset stim", 64'(bi0.stim), 64'd0);
        chk("reset stim_valid", 64'(bi0.stim_valid), 64'd0);
        chk("reset busy/done/pass", {61'd0, busy0, done0, pass0}, 64'd0);
        chk("reset sig", 64'(sig0), 64'd0);
        rst_n  = 1'b1;
        rst3_n = 1'b1;

        // stimulus order and zero-output signature
        exp0 = 32'h0;
        sq0.push_back(64'h00000001);
        sq0.push_back(64'hEDB88320);
        sq0.push_back(64'h76DC4190);
        rq0.push_back('{sig: 32'h0, pass: 1'b1});
        pulse(0);
        chk("u0 ZERO stim", 64'(bi0.stim), 64'd0);
        chk("u0 ZERO valid/busy", {62'd0, bi0.stim_valid, busy0}, 64'd1);
        repeat (4) @(negedge clk);
        chk("u0 post-run stim", 64'(bi0.stim), 64'd0);
        chk("u0 post-run valid", 64'(bi0.stim_valid), 64'd0);
        wait_done(0, "u0");
        repeat (2) @(negedge clk);
        chk("u0 vector count", 64'(nv0), 64'd3);

        // constant ones, matching signature
        exp1 = 32'h6DB88320;
        rq1.push_back('{sig: 32'h6DB88320, pass: 1'b1});
        pulse(1);
        wait_done(1, "u1 pass");
        repeat (2) @(negedge clk);

        // constant ones, wrong golden
        exp1 = 32'h0;
        rq1.push_back('{sig: 32'h6DB88320, pass: 1'b0});
        pulse(1);
        wait_done(1, "u1 fail");
        repeat (2) @(negedge clk);

        // 64-bit ones: chunks cancel
        exp2 = 32'h0;
        rq2.push_back('{sig: 32'h0, pass: 1'b1});
        pulse(2);
        wait_done(2, "u2");
        repeat (2) @(negedge clk);

        // starts while busy and on the CHECK cycle are ignored
        exp1 = 32'h6DB88320;
        rq1.push_back('{sig: 32'h6DB88320, pass: 1'b1});
        d1 = nd1;
        pulse(1);
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_done(1, "u1 ignored");
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("u1 busy cycle after done", 64'(busy1), 64'd0);
        repeat (8) @(negedge clk);
        chk("u1 single done", 64'(nd1 - d1), 64'd1);
        chk("u1 idle after ignored starts", 64'(busy1), 64'd0);

        // reset mid-run at vector 5 of 21
        sq3.push_back(64'h1_00000001);
        sq3.push_back(64'h0_EDB88320);
        sq3.push_back(64'h0_76DC4190);
        nv3 = 0;
        d3 = nd3;
        pulse(3);
        repeat (5) @(negedge clk);
        rst3_n = 1'b0;
        #1;
        chk("u3 vectors before abort", 64'(nv3), 64'd5);
        chk("u3 abort stim", 64'(bi3.stim), 64'd0);
        chk("u3 abort valid/busy/done/pass",
            {60'd0, bi3.stim_valid, busy3, done3, pass3}, 64'd0);
        chk("u3 abort sig", 64'(sig3), 64'd0);
        @(negedge clk);
        rst3_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("u3 no done after abort", 64'(nd3 - d3), 64'd0);
        sq3.push_back(64'h1_00000001);
        sq3.push_back(64'h0_EDB88320);
        sq3.push_back(64'h0_76DC4190);
        nv3 = 0;
        pulse(3);
        wait_done(3, "u3");
        repeat (2) @(negedge clk);
        chk("u3 fresh vector count", 64'(nv3), 64'd21);
        chk("u3 fresh done count", 64'(nd3 - d3), 64'd1);
        chk("u3 seed vectors consumed", 64'(sq3.size()), 64'd0);

`ifdef FUZZ_SIG_MISMATCH_CAPTURE_EN
        // capture 4 has bit 0 flipped; golden is that corrupted signature
        lm = 32'h1;
        mm = 32'h0;
        for (int k = 0; k < 6; k++) begin
            mm = lstep(mm) ^ (lm ^ ((k == 4) ? 32'h1 : 32'h0));
            lm = lstep(lm);
        end
        exp4 = mm;
        rq4.push_back('{sig: mm, pass: 1'b0});
        pulse(4);
        wait_done(4, "u4");
        repeat (2) @(negedge clk);
        chk("u4 result consumed", 64'(rq4.size()), 64'd0);
`endif

        chk("u0 results consumed", 64'(rq0.size() + sq0.size()), 64'd0);
        chk("u1 results consumed", 64'(rq1.size()), 64'd0);
        chk("u2 results consumed", 64'(rq2.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
